// File: rtl/pc_sequencer.sv
// Fetch/execute controller driving the PC select (PS) and the instruction-memory handshake.
// One instruction is FETCH, WAIT (until mem_ready), DECODE, then EXEC (held while stalled).
module pc_sequencer #(
  parameter int unsigned TIMEOUT  = 15,
  parameter int unsigned RETIRE_W = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                mem_ready,
  input  logic                stall,
  input  logic                br_reg,
  input  logic                br_uncond,
  input  logic                br_cond,
  input  logic                cond_met,
  input  logic                halt_instr,
  output logic [1:0]          PS,
  output logic                mem_req,
  output logic                ir_load,
  output logic                exec_en,
  output logic [2:0]          state,
  output logic                fault,
  output logic [RETIRE_W-1:0] retired
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StWait   = 3'd2,
    StDecode = 3'd3,
    StExec   = 3'd4,
    StHalt   = 3'd5,
    StFault  = 3'd6
  } state_e;

  state_e              state_q;
  logic [CntW-1:0]     wait_cnt_q;
  logic [RETIRE_W-1:0] retired_q;
  logic                retire;

  // An instruction completes on the edge that ends a non-stalled EXEC.
  assign retire = (state_q == StExec) && !stall;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      retired_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) state_q <= StFetch;
        end
        StFetch: begin
          state_q    <= StWait;
          wait_cnt_q <= '0;
        end
        StWait: begin
          if (mem_ready) begin
            state_q <= StDecode;
          end else if (wait_cnt_q == CntW'(TIMEOUT)) begin
            state_q <= StFault;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        StDecode: begin
          state_q <= StExec;
        end
        StExec: begin
          if (!stall) state_q <= halt_instr ? StHalt : StFetch;
        end
        StHalt: begin
          if (start) state_q <= StFetch;
        end
        StFault: begin
          state_q <= StFault;
        end
        default: begin
          // Encoding 7 is unreachable in normal operation; treat it as a fault.
          state_q <= StFault;
        end
      endcase
      if (retire) retired_q <= retired_q + 1'b1;
    end
  end

  always_comb begin
    PS = 2'b00;
    if (retire) begin
      if (halt_instr) begin
        PS = 2'b01;
      end else if (br_reg) begin
        PS = 2'b10;
      end else if (br_uncond || (br_cond && cond_met)) begin
        PS = 2'b11;
      end else begin
        PS = 2'b01;
      end
    end
  end

  assign mem_req = (state_q == StFetch) || (state_q == StWait);
  assign ir_load = (state_q == StWait) && mem_ready;
  assign exec_en = retire;
  assign fault   = (state_q == StFault);
  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: each instruction is expanded into its expected cycle-by-cycle
// outputs, queued by the driver and checked by an independent negedge monitor.
module tb_pc_sequencer;

  localparam int unsigned RW = 4;

  localparam logic [2:0] SIdle   = 3'd0;
  localparam logic [2:0] SFetch  = 3'd1;
  localparam logic [2:0] SWait   = 3'd2;
  localparam logic [2:0] SDecode = 3'd3;
  localparam logic [2:0] SExec   = 3'd4;
  localparam logic [2:0] SHalt   = 3'd5;
  localparam logic [2:0] SFault  = 3'd6;

  logic clock, reset, start, mem_ready, stall;
  logic br_reg, br_uncond, br_cond, cond_met, halt_instr;
  logic [1:0]    PS;
  logic          mem_req, ir_load, exec_en, fault;
  logic [2:0]    state;
  logic [RW-1:0] retired;

  pc_sequencer #(.TIMEOUT(15), .RETIRE_W(RW)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .mem_ready (mem_ready),
    .stall     (stall),
    .br_reg    (br_reg),
    .br_uncond (br_uncond),
    .br_cond   (br_cond),
    .cond_met  (cond_met),
    .halt_instr(halt_instr),
    .PS        (PS),
    .mem_req   (mem_req),
    .ir_load   (ir_load),
    .exec_en   (exec_en),
    .state     (state),
    .fault     (fault),
    .retired   (retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0]    st;
    logic [1:0]    ps;
    logic          mreq;
    logic          irl;
    logic          exe;
    logic          flt;
    logic [RW-1:0] ret;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    n_ret    = 0;

  function automatic void chk(input string t, input string f, input int unsigned got,
                              input int unsigned want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s.%s got %0h expected %0h at %0t", t, f, got, want, $time);
    end
  endfunction

  // Monitor: compares one queued expectation per cycle, away from the active edge.
  always @(negedge clock) begin
    exp_t  e;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, "state",   32'(state),   32'(e.st));
      chk(t, "PS",      32'(PS),      32'(e.ps));
      chk(t, "mem_req", 32'(mem_req), 32'(e.mreq));
      chk(t, "ir_load", 32'(ir_load), 32'(e.irl));
      chk(t, "exec_en", 32'(exec_en), 32'(e.exe));
      chk(t, "fault",   32'(fault),   32'(e.flt));
      chk(t, "retired", 32'(retired), 32'(e.ret));
    end
  end

  // PC select chosen by a completing instruction's decode flags.
  function automatic logic [1:0] ps_ref(input logic hi, rg, un, cd, cm);
    if (hi)             return 2'b01;
    if (rg)             return 2'b10;
    if (un || (cd && cm)) return 2'b11;
    return 2'b01;
  endfunction

  task automatic cyc(input logic [2:0] st, input logic [1:0] ps, input logic mreq, irl, exe, flt,
                     input string tag);
    exp_t e;
    e.st = st; e.ps = ps; e.mreq = mreq; e.irl = irl; e.exe = exe; e.flt = flt;
    e.ret = RW'(n_ret);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clock);
    #1;
  endtask

  task automatic rand_dc();
    stall      = 1'($urandom);
    br_reg     = 1'($urandom);
    br_uncond  = 1'($urandom);
    br_cond    = 1'($urandom);
    cond_met   = 1'($urandom);
    halt_instr = 1'($urandom);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    n_ret = 0;
    cyc(SIdle, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, tag);
    reset = 1'b1;
  endtask

  task automatic kick(input logic [2:0] st, input string tag);
    start = 1'b1;
    cyc(st, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, tag);
    start = 1'b0;
  endtask

  // One instruction starting in FETCH. abort: 1 = reset in WAIT, 2 = reset in final EXEC cycle.
  task automatic run_instr(input int misses, input int stalls, input logic hi, rg, un, cd, cm,
                           input int abort, input string tag);
    rand_dc();
    mem_ready = 1'($urandom);
    cyc(SFetch, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, {tag, "/fetch"});
    for (int i = 0; i < misses; i++) begin
      rand_dc();
      mem_ready = 1'b0;
      cyc(SWait, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, {tag, "/miss"});
    end
    if (abort == 1) begin
      mem_ready = 1'b0;
      do_reset({tag, "/rst"});
      return;
    end
    rand_dc();
    mem_ready = 1'b1;
    cyc(SWait, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, {tag, "/ready"});
    rand_dc();
    mem_ready = 1'($urandom);
    cyc(SDecode, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, {tag, "/decode"});
    halt_instr = hi; br_reg = rg; br_uncond = un; br_cond = cd; cond_met = cm;
    for (int i = 0; i < stalls; i++) begin
      stall = 1'b1;
      mem_ready = 1'($urandom);
      cyc(SExec, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, {tag, "/stall"});
    end
    stall = 1'b0;
    if (abort == 2) begin
      do_reset({tag, "/rst"});
      return;
    end
    cyc(SExec, ps_ref(hi, rg, un, cd, cm), 1'b0, 1'b0, 1'b1, 1'b0, {tag, "/exec"});
    n_ret++;
  endtask

  task automatic halt_wait(input int n, input string tag);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      rand_dc();
      mem_ready = 1'($urandom);
      cyc(SHalt, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, tag);
    end
    kick(SHalt, {tag, "/start"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int misses, stalls;
    logic hi, rg, un, cd, cm;
    reset = 1'b0; start = 1'b0; mem_ready = 1'b0; stall = 1'b0;
    br_reg = 1'b0; br_uncond = 1'b0; br_cond = 1'b0; cond_met = 1'b0; halt_instr = 1'b0;
    @(posedge clock);
    #1;
    do_reset("por");
    kick(SIdle, "idle");

    repeat (3) run_instr(0, 0, 0, 0, 0, 0, 0, 0, "plain");
    run_instr(0, 0, 0, 0, 1, 0, 0, 0, "uncond");
    run_instr(0, 0, 0, 0, 0, 1, 0, 0, "cond_no");
    run_instr(0, 0, 0, 0, 0, 1, 1, 0, "cond_yes");
    run_instr(0, 0, 0, 1, 1, 0, 0, 0, "reg_prio");
    run_instr(0, 3, 0, 0, 0, 0, 0, 0, "stall3");
    run_instr(15, 0, 0, 0, 0, 0, 0, 0, "miss15");
    run_instr(0, 0, 1, 1, 1, 1, 1, 0, "halt");
    halt_wait(10, "halted");
    run_instr(1, 1, 0, 0, 0, 0, 0, 0, "after_halt");

    run_instr(2, 0, 0, 0, 0, 0, 0, 1, "rst_wait");
    kick(SIdle, "idle2");
    run_instr(0, 0, 0, 0, 1, 0, 0, 2, "rst_exec");
    cyc(SIdle, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, "post_rst");
    kick(SIdle, "idle3");

    // 16 consecutive misses: FAULT, absorbing until reset.
    rand_dc();
    cyc(SFetch, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, "flt/fetch");
    for (int i = 0; i < 16; i++) begin
      rand_dc();
      mem_ready = 1'b0;
      cyc(SWait, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, "flt/miss");
    end
    for (int i = 0; i < 5; i++) begin
      rand_dc();
      start = 1'b1;
      mem_ready = 1'b1;
      cyc(SFault, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, "flt/sticky");
    end
    start = 1'b0;
    do_reset("flt/rst");
    kick(SIdle, "idle4");

    // Random instruction mix; more than 2^RW completions exercises the retired wrap.
    for (int k = 0; k < 40; k++) begin
      misses = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 0;
      stalls = int'($urandom_range(0, 3));
      hi = ($urandom_range(0, 7) == 0);
      rg = 1'($urandom); un = 1'($urandom); cd = 1'($urandom); cm = 1'($urandom);
      run_instr(misses, stalls, hi, rg, un, cd, cm, 0, "rand");
      if (hi) halt_wait(int'($urandom_range(0, 10)), "rand_halt");
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle fetch/execute controller that sequences the 32-bit program counter by driving its 2-bit PS select. It runs the instruction-memory handshake, loads the instruction register, and on each instruction's execute cycle selects hold, sequential, register-absolute or PC-relative update. It sits between the decoder/flag logic and the PC block, and is the only driver of PS.

## Interface
- TIMEOUT, default 15: maximum WAIT cycles without mem_ready before FAULT; 1..255.
- RETIRE_W, default 16: width of the retired-instruction counter.

- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  leave IDLE or HALT and begin fetching.
- mem_ready  in  1  instruction memory has the word on its bus this cycle.
- stall  in  1  datapath hazard; freezes EXEC.
- br_reg  in  1  decoded register-absolute branch; PC source is the `in` operand.
- br_uncond  in  1  decoded unconditional relative branch.
- br_cond  in  1  decoded conditional relative branch.
- cond_met  in  1  condition true for br_cond.
- halt_instr  in  1  decoded halt.
- PS  out  2  PC select: 00 hold, 01 PC+4, 10 load `in`, 11 PC+4+in*4.
- mem_req  out  1  instruction fetch request.
- ir_load  out  1  instruction register load strobe.
- exec_en  out  1  datapath execute/writeback enable.
- state  out  3  current state encoding.
- fault  out  1  memory-timeout fault, sticky until reset.
- retired  out  RETIRE_W  count of completed instructions.

## Operation
- States: IDLE=0, FETCH=1, WAIT=2, DECODE=3, EXEC=4, HALT=5, FAULT=6. Encoding 7 is illegal and goes to FAULT next cycle.
- IDLE: start goes to FETCH, otherwise stay in IDLE.
- FETCH: unconditionally goes to WAIT. mem_ready is ignored in FETCH.
- WAIT: mem_ready goes to DECODE. Otherwise the wait counter increments; a miss on the cycle the counter equals TIMEOUT goes to FAULT.
- DECODE: always goes to EXEC, giving decoder outputs one cycle to settle.
- EXEC, in priority order:
  - stall: stay in EXEC.
  - halt_instr: go to HALT.
  - br_reg: go to FETCH.
  - br_uncond: go to FETCH.
  - br_cond & cond_met: go to FETCH.
  - otherwise: go to FETCH.
- HALT: start goes to FETCH.
- FAULT: absorbing; only reset leaves it.
- Outputs (combinational from state and inputs):
  - mem_req = FETCH or WAIT.
  - ir_load = WAIT & mem_ready.
  - exec_en = EXEC & ~stall.
  - fault = (state == FAULT).
- PS is 00 in every state except EXEC & ~stall. In that case:
  - halt_instr gives 01.
  - else br_reg gives 10.
  - else br_uncond gives 11.
  - else br_cond & cond_met gives 11.
  - else 01.
- Consequence: the PC changes exactly once per instruction, on the clock edge that ends EXEC.
- Wait counter clears on entry to WAIT; its width is ceil(log2(TIMEOUT+1)).
- retired increments on every edge that ends a non-stalled EXEC, halt included. It wraps modulo 2^RETIRE_W with no saturation.
- Simultaneous branch flags resolve by the priority above. There is no error for conflicting flags.
- Decoder inputs are sampled only in EXEC; their values in other states are don't-care.

## Timing
- Reset (reset=0, asynchronous):
  - state=IDLE, PS=00, mem_req=0, ir_load=0, exec_en=0, fault=0, retired=0, wait counter=0.
  - Takes effect immediately, mid-instruction included; no partial PC update occurs.
- Reset release is synchronous to the next clock edge; start is honoured from the first edge after release.
- Minimum instruction time is 4 cycles (FETCH, WAIT with ready, DECODE, EXEC). Each WAIT miss and each stall cycle adds 1.
- The PC update and the retired increment occur on the same edge.
- From HALT, the first fetch is at the already-advanced PC+4.
- FAULT is entered on the edge after the (TIMEOUT+1)th consecutive WAIT cycle without mem_ready.

## Test plan
- Reset then start, mem_ready held 1, all decode 0: state 0→1→2→3→4→1 repeating. PS=01 only in EXEC. retired=1,2,3 after 4, 8, 12 cycles.
- Relative branches in EXEC:
  - br_uncond=1: PS=11 for exactly one cycle.
  - br_cond=1, cond_met=0: PS=01.
  - br_cond=1, cond_met=1: PS=11.
  - br_reg=1 with br_uncond=1: PS=10 (priority).
- stall held 3 cycles in EXEC: PS=00 and exec_en=0 for 3 cycles. Then PS=01 and exec_en=1 for one cycle. retired increments once.
- mem_ready withheld for 15 WAIT cycles then asserted: reaches DECODE, no fault. Withheld 16 cycles: state=6, fault=1, mem_req=0. fault stays 1 until reset.
- halt_instr in EXEC: PS=01, state=5, mem_req=0 thereafter. A start pulse 10 cycles later returns to FETCH.
- Reset asserted in WAIT and in EXEC with br_uncond: all outputs return to reset values immediately. No PS=11 on the next edge. retired=0.
- retired at 2^RETIRE_W−1 plus one more instruction wraps to 0.
